corevx_ptw_arbiter: RTL

Shares one corevx_ptw page-table walker between two TLB-miss requesters: port 0 (ITLB) and port 1 (DTLB).
Selects requesters round-robin and drives the PTW resolve interface, holding the request stable until the walk completes.
Routes the walk result back to the granted requester as a one-cycle registered pulse.
Includes a watchdog that converts a hung walk into an access fault, so the requesting pipeline stage cannot deadlock.

---
 rtl/corevx_ptw_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/corevx_ptw_arbiter.sv
// Round-robin arbiter sharing one page-table walker between the ITLB (port 0)
// and DTLB (port 1), with a watchdog that turns a hung walk into an access fault.
module corevx_ptw_arbiter #(
  parameter int WATCHDOG_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  input  logic [19:0] req0_vaddr,
  output logic        req0_ready,
  output logic        req0_done,
  output logic        req0_pagefault,
  output logic        req0_accessfault,
  output logic [7:0]  req0_access_bits,
  output logic [21:0] req0_physical_address,

  input  logic        req1_valid,
  input  logic [19:0] req1_vaddr,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        req1_pagefault,
  output logic        req1_accessfault,
  output logic [7:0]  req1_access_bits,
  output logic [21:0] req1_physical_address,

  output logic        ptw_resolve_request,
  output logic [31:0] ptw_resolve_virtual_address,
  input  logic        ptw_resolve_done,
  input  logic        ptw_resolve_pagefault,
  input  logic        ptw_resolve_accessfault,
  input  logic [7:0]  ptw_resolve_access_bits,
  input  logic [21:0] ptw_resolve_physical_address,

  output logic        busy,
  output logic        grant_id,
  output logic        watchdog_error
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  localparam logic [9:0] WD_LIMIT = 10'(WATCHDOG_CYCLES);
  localparam bit         WD_EN    = (WATCHDOG_CYCLES != 0);
  // Result word layout: {pagefault, accessfault, access_bits[7:0], ppn[21:0]}
  localparam logic [31:0] WD_RESULT = {1'b0, 1'b1, 8'h00, 22'h000000};

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic [19:0] vaddr_q, vaddr_d;
  logic [9:0]  wd_cnt_q, wd_cnt_d;
  logic        wd_err_q, wd_err_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [31:0] res0_q, res0_d;
  logic [31:0] res1_q, res1_d;
  logic [31:0] ptw_result;

  assign ptw_result = {ptw_resolve_pagefault, ptw_resolve_accessfault,
                       ptw_resolve_access_bits, ptw_resolve_physical_address};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    vaddr_d      = vaddr_q;
    wd_cnt_d     = wd_cnt_q;
    wd_err_d     = wd_err_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time is granted.
        if (req0_valid && (!req1_valid || last_grant_q)) begin
          req0_ready   = 1'b1;
          vaddr_d      = req0_vaddr;
          grant_d      = 1'b0;
          last_grant_d = 1'b0;
          wd_cnt_d     = '0;
          state_d      = BUSY;
        end else if (req1_valid) begin
          req1_ready   = 1'b1;
          vaddr_d      = req1_vaddr;
          grant_d      = 1'b1;
          last_grant_d = 1'b1;
          wd_cnt_d     = '0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (ptw_resolve_done) begin
          state_d = IDLE;
          if (grant_q) begin
            res1_d  = ptw_result;
            done1_d = 1'b1;
          end else begin
            res0_d  = ptw_result;
            done0_d = 1'b1;
          end
        end else if (WD_EN && (wd_cnt_q == WD_LIMIT)) begin
          // Walker still owns the request, so park in DRAIN until it finishes.
          state_d  = DRAIN;
          wd_err_d = 1'b1;
          if (grant_q) begin
            res1_d  = WD_RESULT;
            done1_d = 1'b1;
          end else begin
            res0_d  = WD_RESULT;
            done0_d = 1'b1;
          end
        end else begin
          wd_cnt_d = wd_cnt_q + 10'd1;
        end
      end
      DRAIN: begin
        if (ptw_resolve_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      vaddr_q      <= '0;
      wd_cnt_q     <= '0;
      wd_err_q     <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      res0_q       <= '0;
      res1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      vaddr_q      <= vaddr_d;
      wd_cnt_q     <= wd_cnt_d;
      wd_err_q     <= wd_err_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
    end
  end

  assign busy                        = (state_q != IDLE);
  assign ptw_resolve_request         = (state_q != IDLE);
  assign ptw_resolve_virtual_address = {vaddr_q, 12'h000};
  assign grant_id                    = grant_q;
  assign watchdog_error              = wd_err_q;

  assign req0_done             = done0_q;
  assign req0_pagefault        = res0_q[31];
  assign req0_accessfault      = res0_q[30];
  assign req0_access_bits      = res0_q[29:22];
  assign req0_physical_address = res0_q[21:0];

  assign req1_done             = done1_q;
  assign req1_pagefault        = res1_q[31];
  assign req1_accessfault      = res1_q[30];
  assign req1_access_bits      = res1_q[29:22];
  assign req1_physical_address = res1_q[21:0];

endmodule
